// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: transmit FSM state encoding and frame length helper,
// used by both the transmit and receive paths.
package rs232_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    function automatic int frame_bits(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Free-running bit-period counter: counts 0..BAUD_COUNT-1 and pulses tick on the last count.
// Holding clear keeps the counter at zero so the first bit after a load gets a full period.
module rs232_baud_tick #(
    parameter int BAUD_COUNT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int COUNT_WIDTH = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(BAUD_COUNT - 1);

    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

    assign tick = (count == LAST_COUNT);

endmodule

// File: rtl/rs232_tx_serializer.sv
// RS-232 transmitter: start bit, DATA_WIDTH data bits LSB first, one stop bit.
// A one-word holding register lets the next frame follow the stop bit with no idle gap.
//   state    | meaning
//   TX_IDLE  | line high, waiting for a word
//   TX_START | start bit (0) on the line
//   TX_DATA  | data bits, bit_idx counts them
//   TX_STOP  | stop bit (1); at its end reload from holding/input or go idle
module rs232_tx_serializer
    import rs232_pkg::*;
#(
    parameter int BAUD_COUNT = 434,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] transmit_data,
    input  logic                  transmit_data_valid,
    output logic                  transmit_data_ready,
    output logic                  serial_data_out,
    output logic                  transmitting_data,
    output logic                  data_transmitted,
    output logic                  baud_clock
);

    localparam int SHIFT_WIDTH = frame_bits(DATA_WIDTH) - 1;
    localparam int IDX_WIDTH = $clog2(frame_bits(DATA_WIDTH));
    localparam logic [IDX_WIDTH-1:0] LAST_DATA_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

    tx_state_t              state;
    logic [SHIFT_WIDTH-1:0] shifter;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   hold_full;
    logic [IDX_WIDTH-1:0]   bit_idx;

    logic                   tick;
    logic                   baud_clear;
    logic                   accept;
    logic                   frame_end;
    logic                   load_hold;
    logic                   load_input;
    logic                   load;
    logic                   to_hold;
    logic                   hold_full_next;
    logic [DATA_WIDTH-1:0]  load_word;

    assign baud_clear = (state == TX_IDLE);

    rs232_baud_tick #(
        .BAUD_COUNT(BAUD_COUNT)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    // A buffered word always wins the stop-bit reload; ready is low then, so no new word competes.
    always_comb begin
        accept         = transmit_data_valid && transmit_data_ready;
        frame_end      = (state == TX_STOP) && tick;
        load_hold      = frame_end && hold_full;
        load_input     = accept && !hold_full && ((state == TX_IDLE) || frame_end);
        to_hold        = accept && !load_input;
        load           = load_hold || load_input;
        load_word      = load_hold ? hold_data : transmit_data;
        hold_full_next = to_hold || (hold_full && !load_hold);
    end

    assign data_transmitted = frame_end;
    assign baud_clock       = tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= TX_IDLE;
            shifter             <= '1;
            bit_idx             <= '0;
            hold_data           <= '0;
            hold_full           <= 1'b0;
            serial_data_out     <= 1'b1;
            transmitting_data   <= 1'b0;
            transmit_data_ready <= 1'b0;
        end else begin
            if (to_hold) begin
                hold_data <= transmit_data;
            end
            hold_full           <= hold_full_next;
            transmit_data_ready <= !hold_full_next;

            case (state)
                TX_IDLE: begin
                    if (load) begin
                        state             <= TX_START;
                        serial_data_out   <= 1'b0;
                        shifter           <= {1'b1, load_word};
                        transmitting_data <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        state           <= TX_DATA;
                        bit_idx         <= '0;
                        serial_data_out <= shifter[0];
                        shifter         <= {1'b1, shifter[SHIFT_WIDTH-1:1]};
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        serial_data_out <= shifter[0];
                        shifter         <= {1'b1, shifter[SHIFT_WIDTH-1:1]};
                        if (bit_idx == LAST_DATA_IDX) begin
                            state <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_WIDTH'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (load) begin
                            state           <= TX_START;
                            serial_data_out <= 1'b0;
                            shifter         <= {1'b1, load_word};
                        end else begin
                            state             <= TX_IDLE;
                            serial_data_out   <= 1'b1;
                            transmitting_data <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rs232_tx_serializer.md
# rs232_tx_serializer

Asynchronous serial (RS-232 style) transmitter converting parallel words into 8N1-style frames on a single line. It is the transmit counterpart of the team's RS-232 receive path and shares its baud parameterisation, so both directions run at the same bit rate. It sits between on-chip producers (event formatter, debug/command responses) and the UART TX pin. A one-entry holding register allows back-to-back frames with no idle gap.

## Interface

**Parameters**
- `BAUD_COUNT`, default 434: clk cycles per serial bit; must be ≥ 2.
- `DATA_WIDTH`, default 8: data bits per frame.

**Ports**
- `clk` input, 1: clock.
- `reset` input, 1: synchronous, active-high.
- `transmit_data` input, DATA_WIDTH: word to send.
- `transmit_data_valid` input, 1: producer offers `transmit_data`.
- `transmit_data_ready` output, 1: block can accept a word this cycle.
- `serial_data_out` output, 1: TX line; idle high.
- `transmitting_data` output, 1: a frame is on the line.
- `data_transmitted` output, 1: one-cycle pulse at frame completion.
- `baud_clock` output, 1: one-cycle pulse at every bit boundary while transmitting.

## Operation

- **Frame format:** start bit (0), then DATA_WIDTH data bits LSB first, then one stop bit (1). Total DATA_WIDTH+2 bits.
- **Handshake:**
  - A transfer occurs on a rising edge where `transmit_data_valid && transmit_data_ready`.
  - The producer must hold `transmit_data` stable while valid is high and ready is low.
- **Storage:** shift register plus one holding register. `transmit_data_ready` is registered and equals "holding register empty".
- **Routing an accepted word:**
  - If the shifter is idle, or finishing its stop bit on that same edge, the word loads straight into the shifter.
  - Otherwise it goes into the holding register.
- **End of stop bit:**
  - If the holding register is full, its word moves into the shifter and the next start bit begins immediately.
  - Otherwise the FSM returns to IDLE.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE→START on load.
  - START→DATA after 1 bit time.
  - DATA→STOP after DATA_WIDTH bit times.
  - STOP→START (holding full, or valid&&ready on that edge) or STOP→IDLE, after 1 bit time.
- **Counters:**
  - Baud counter width `$clog2(BAUD_COUNT)`. Counts 0..BAUD_COUNT-1 and wraps; held at 0 in IDLE.
  - Bit index width `$clog2(DATA_WIDTH+2)`.
- **Output behaviour:**
  - `serial_data_out` is registered, driven from the shifter LSB.
  - `transmitting_data` is high in START/DATA/STOP.
  - `baud_clock` pulses when the baud counter equals BAUD_COUNT-1.

## Timing

- **Reset values:** `serial_data_out`=1, `transmitting_data`=0, `data_transmitted`=0, `baud_clock`=0, `transmit_data_ready`=0. Ready rises on the first edge after reset deasserts.
- **Reset mid-frame:**
  - Line returns to 1 on the next edge.
  - Holding register is discarded.
  - No `data_transmitted` pulse is produced.
- **Latency:** when idle, the line goes low in the cycle following the accepting edge.
- **Bit timing:** every bit lasts exactly BAUD_COUNT cycles. A frame lasts (DATA_WIDTH+2)·BAUD_COUNT cycles.
- **`data_transmitted`:** asserted for exactly one cycle, in the last cycle of the stop bit, coincident with the final `baud_clock` pulse.
- **Back-to-back frames:** no idle cycles between the stop bit and the next start bit.
- **Ready during a frame:** stays high after the first word is accepted, so a second word can be buffered. It falls on the edge that fills the holding register and rises on the edge that drains it.
- **Simultaneous events:** at stop-bit end with the holding register full and valid high, the buffered word goes to the shifter. The new word waits, because ready was low.

## Structure

- **Package `rs232_pkg`:** FSM state enum (`tx_state_t`) and a frame-length constant function (DATA_WIDTH+2). These are shared with the receive side.
- **Sub-module `rs232_baud_tick`:**
  - Inputs: `clk`, `reset`, `clear`.
  - Output: `tick`.
  - Parameter: BAUD_COUNT.
  - Implements the free-running bit-period counter. This block and the receiver can both reuse it.
- **Top level:** FSM, shifter, holding register, handshake.

## Test plan

- **Reset idle:** hold reset 5 cycles, then release → `serial_data_out`=1 throughout. Ready low during reset and high 1 cycle after.
- **Single byte (BAUD_COUNT=4):** send 0xA5 → line pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. One `data_transmitted` pulse at cycle 40. 10 `baud_clock` pulses.
- **Back-to-back:** push 0x00, 0xFF, 0x3C with valid held high → ready drops after the second word is accepted. Three frames are contiguous with zero idle cycles; 3 pulses spaced 40 cycles apart.
- **Stop-edge collision:** offer a word exactly on the stop-bit-final cycle with the buffer empty → the next start bit follows immediately.
- **Mid-frame reset:** assert reset during data bit 3 of 0x81 → line is 1 on the next edge, no completion pulse. The next frame after release is correct.
- **Default rate:** BAUD_COUNT=434, DATA_WIDTH=8, send 0x55 → each bit measures 434 cycles; frame length is 4340 cycles.
